// File: rtl/pl0_uart_bridge.sv
// UART console bridge for the PL/0 machine: TX FIFO + 8N1 serialiser, 2-flop synced deserialiser.
// Define PL0_UART_PARITY_EN to add an even-parity bit to both directions.
module pl0_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_out,
    input  logic       char_out_valid,
    output logic [7:0] char_in,
    output logic       char_in_valid,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       rx_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   FULL     = (PW + 1)'(TX_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef PL0_UART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef PL0_UART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en, tx_pop;
    logic [7:0]    head;

    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic [7:0]    tx_sh_q;
    logic          uart_tx_q, tx_busy_q;
    logic          tx_bit_end;

    assign head       = fifo_mem[rd_ptr_q];
    assign tx_bit_end = (tx_cnt_q == BIT_END);

    always_comb begin
        // The serialiser pops from IDLE, or at the last stop-bit cycle to chain frames without a gap.
        tx_pop   = (count_q != '0) &&
                   ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_bit_end));
        wr_en    = char_out_valid && ((count_q != FULL) || tx_pop);
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(tx_pop);
        count_d  = count_q + (PW + 1)'(wr_en) - (PW + 1)'(tx_pop);
        ovf_d    = ovf_q | (char_out_valid & ~wr_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= char_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ---------------- TX serialiser ----------------
`ifdef PL0_UART_PARITY_EN
    logic tx_par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef PL0_UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + CW'(1);
            if (tx_pop) begin
                tx_state_q <= TX_START;
                tx_cnt_q   <= '0;
                tx_idx_q   <= '0;
                tx_sh_q    <= head;
                uart_tx_q  <= 1'b0;
                tx_busy_q  <= 1'b1;
`ifdef PL0_UART_PARITY_EN
                tx_par_q   <= ^head;
`endif
            end else begin
                case (tx_state_q)
                    TX_IDLE: tx_cnt_q <= '0;
                    TX_START: if (tx_bit_end) begin
                        tx_state_q <= TX_DATA;
                        uart_tx_q  <= tx_sh_q[0];
                    end
                    TX_DATA: if (tx_bit_end) begin
                        if (tx_idx_q == 3'd7) begin
`ifdef PL0_UART_PARITY_EN
                            tx_state_q <= TX_PAR;
                            uart_tx_q  <= tx_par_q;
`else
                            tx_state_q <= TX_STOP;
                            uart_tx_q  <= 1'b1;
`endif
                        end else begin
                            tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
                            uart_tx_q <= tx_sh_q[1];
                            tx_idx_q  <= tx_idx_q + 3'd1;
                        end
                    end
`ifdef PL0_UART_PARITY_EN
                    TX_PAR: if (tx_bit_end) begin
                        tx_state_q <= TX_STOP;
                        uart_tx_q  <= 1'b1;
                    end
`endif
                    TX_STOP: if (tx_bit_end) begin
                        tx_state_q <= TX_IDLE;
                        tx_busy_q  <= 1'b0;
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                        uart_tx_q  <= 1'b1;
                        tx_busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- RX deserialiser ----------------
    rx_state_e     rx_state_q;
    logic          rx_s1_q, rx_s2_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_sh_q;
    logic [7:0]    char_in_q;
    logic          char_in_valid_q, rx_err_q;
    logic          rx_bit_end;
`ifdef PL0_UART_PARITY_EN
    logic          rx_par_err_q;
`endif

    assign rx_bit_end = (rx_cnt_q == BIT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q      <= RX_IDLE;
            rx_s1_q         <= 1'b1;
            rx_s2_q         <= 1'b1;
            rx_cnt_q        <= '0;
            rx_idx_q        <= '0;
            rx_sh_q         <= '0;
            char_in_q       <= '0;
            char_in_valid_q <= 1'b0;
            rx_err_q        <= 1'b0;
`ifdef PL0_UART_PARITY_EN
            rx_par_err_q    <= 1'b0;
`endif
        end else begin
            rx_s1_q         <= uart_rx;
            rx_s2_q         <= rx_s1_q;
            char_in_valid_q <= 1'b0;
            rx_err_q        <= 1'b0;
            rx_cnt_q        <= rx_bit_end ? '0 : rx_cnt_q + CW'(1);
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_s2_q) rx_state_q <= RX_START;
                end
                // Half-bit re-sample rejects glitches and centres later samples in each bit.
                RX_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q   <= '0;
                    rx_idx_q   <= '0;
                    rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_bit_end) begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_idx_q <= rx_idx_q + 3'd1;
`ifdef PL0_UART_PARITY_EN
                    if (rx_idx_q == 3'd7) rx_state_q <= RX_PAR;
`else
                    if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
`endif
                end
`ifdef PL0_UART_PARITY_EN
                RX_PAR: if (rx_bit_end) begin
                    rx_par_err_q <= rx_s2_q ^ (^rx_sh_q);
                    rx_state_q   <= RX_STOP;
                end
`endif
                RX_STOP: if (rx_bit_end) begin
                    if (rx_s2_q) begin
                        rx_state_q <= RX_IDLE;
`ifdef PL0_UART_PARITY_EN
                        if (rx_par_err_q) begin
                            rx_err_q <= 1'b1;
                        end else begin
                            char_in_q       <= rx_sh_q;
                            char_in_valid_q <= 1'b1;
                        end
`else
                        char_in_q       <= rx_sh_q;
                        char_in_valid_q <= 1'b1;
`endif
                    end else begin
                        rx_err_q   <= 1'b1;
                        rx_state_q <= RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    rx_cnt_q <= '0;
                    if (rx_s2_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign uart_tx       = uart_tx_q;
    assign tx_busy       = tx_busy_q;
    assign tx_overflow   = ovf_q;
    assign char_in       = char_in_q;
    assign char_in_valid = char_in_valid_q;
    assign rx_err        = rx_err_q;
endmodule

// File: doc/pl0_uart_bridge.md
# pl0_uart_bridge

Serial console bridge on the far side of the PL/0 machine's character I/O port. Bytes the machine emits on `char_out`/`char_out_valid` are buffered in a TX FIFO and serialised as 8N1 UART frames on `uart_tx`. Frames arriving on `uart_rx` are deserialised and presented to the machine as `char_in` with a one-cycle `char_in_valid` strobe. It sits between `pl0_machine` and the board-level serial pins.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; minimum 4.
- `TX_DEPTH`, 8: TX FIFO entries; must be a power of two, 2 to 64.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_out`  in  8  byte from the machine.
- `char_out_valid`  in  1  single-cycle write strobe for `char_out`.
- `char_in`  out  8  last received byte, held until the next good frame.
- `char_in_valid`  out  1  one-cycle strobe when `char_in` updates.
- `uart_tx`  out  1  serial output, idle high.
- `uart_rx`  in  1  serial input, asynchronous to `clk`.
- `tx_busy`  out  1  high while a frame is on the wire or the FIFO is non-empty.
- `tx_overflow`  out  1  sticky; set when a byte is dropped on a full FIFO.
- `rx_err`  out  1  one-cycle strobe on a framing error (or a parity error; see Configuration).

## Operation
- Reset values: `uart_tx`=1, `char_in`=0, `char_in_valid`=0, `tx_busy`=0, `tx_overflow`=0, `rx_err`=0. Reset also empties the FIFO, sends both FSMs to IDLE and presets the RX synchroniser to 1.
- TX FIFO write:
  - A write occurs when `char_out_valid`=1 and either count<`TX_DEPTH` or a pop happens in the same cycle.
  - Otherwise the byte is dropped and `tx_overflow` is set. It clears only on reset.
- TX FSM states: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, it pops the head into a shift register and enters START.
  - Every bit lasts exactly `CLKS_PER_BIT` cycles.
  - At the end of STOP, if the FIFO is non-empty, it pops and goes straight to START with no idle gap.
- RX path:
  - `uart_rx` passes through a 2-flop synchroniser.
  - IDLE: a low on the synchronised line enters START.
  - START: after `CLKS_PER_BIT/2` cycles the line is re-sampled. If it is high, this is a false start and the FSM returns to IDLE with no strobe.
  - DATA: each bit is sampled `CLKS_PER_BIT` cycles after the previous sample, 8 bits LSB first.
  - STOP: one sample.
    - Sample=1: `char_in` is loaded and `char_in_valid` pulses.
    - Sample=0: `rx_err` pulses, `char_in` is unchanged, and the FSM enters WAIT_HIGH. It stays there until the line reads 1, then returns to IDLE.
- Counters are sized `$clog2(CLKS_PER_BIT)` bits; FIFO pointers are `$clog2(TX_DEPTH)` bits and wrap naturally.

## Timing
- TX latency:
  - A byte written at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1.
  - `uart_tx` goes low after edge E+1.
  - A frame occupies 10×`CLKS_PER_BIT` cycles.
- `tx_busy` rises the cycle after the write edge. It falls the cycle after the last stop-bit cycle when the FIFO is empty.
- RX latency: `char_in_valid` and `rx_err` assert in the cycle after the stop-bit sample edge.
- Synchroniser delay: 2 cycles from a `uart_rx` pin change to FSM visibility.
- Reset mid-frame: `uart_tx` returns high immediately (asynchronous), the partial frame is lost and any queued bytes are discarded.
- TX and RX are fully independent and may be active simultaneously.

## Configuration
- `PL0_UART_PARITY_EN` defined:
  - TX inserts an even-parity bit between DATA and STOP, giving 11×`CLKS_PER_BIT` cycles per frame.
  - RX samples a parity bit before STOP. On a mismatch it pulses `rx_err`, suppresses `char_in_valid`, leaves `char_in` unchanged and still checks the stop bit.
- Not defined: 8N1 only; no parity state exists in either FSM.

## Test plan
- Single TX byte (`CLKS_PER_BIT`=16):
  - Stimulus: `char_out`=0x41 strobed once.
  - Response: `uart_tx` low for 16 cycles, then bits 1,0,0,0,0,0,1,0 for 16 cycles each, then high for 16 cycles.
  - `tx_busy` is high for 160 cycles.
- TX overflow (`TX_DEPTH`=8):
  - Stimulus: 10 consecutive `char_out_valid` cycles with bytes 0x30..0x39.
  - Response: 0x30..0x38 are transmitted back-to-back with no gaps, 0x39 is dropped and `tx_overflow`=1.
- RX good frame: drive a 0x5A frame on `uart_rx` → `char_in`=0x5A and `char_in_valid` is high for exactly 1 cycle, with `rx_err`=0.
- RX glitch: `uart_rx` low for 4 cycles, then high → no `char_in_valid`, no `rx_err`, RX FSM back in IDLE.
- RX framing error (`char_in` holding 0x5A beforehand):
  - Stimulus: a frame with data 0x33 and the stop bit driven 0, with the line held low for 2 more bit times.
  - Response: one `rx_err` pulse, `char_in` stays 0x5A, and the next valid frame after the line returns high is received correctly.
- Reset mid-TX: assert `rst_n`=0 during DATA with 3 bytes queued → `uart_tx`=1 immediately, and after release `tx_busy`=0 with no further frames sent.
